irq_scheduler: RTL



---
 rtl/irq_scheduler_pkg.sv | 29 ++
 rtl/irq_scheduler_rr_arbiter.sv | 37 +++
 rtl/irq_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/irq_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types, default parameters and helpers for irq_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int DEF_NUM_SRC     = 4;
    localparam int DEF_FRAME_DIV   = 833333;
    localparam int DEF_ACK_TIMEOUT = 64;
    localparam int DROP_W          = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first pending source at
//               or after the pointer, searching upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] pending,
    input  logic [IDX_W-1:0]   pointer,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int w_idx;

    // Scan offsets high to low so the smallest offset from the pointer wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_idx = (int'(pointer) + i) % NUM_SRC;
            if (pending[w_idx]) begin
                grant_idx   = w_idx[IDX_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : irq_scheduler
// Description : Latches frame-tick and external events as pending interrupts
//               and issues them round-robin as 32-bit instructions to the CPU.
//               IRQ_ONESHOT_EN selects a one-cycle issue without cpu_ack.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_scheduler
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int FRAME_DIV   = DEF_FRAME_DIV,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  proc_clk,
    input  logic                  reset,
    input  logic [NUM_SRC-2:0]    src_evt,
    input  logic [32*NUM_SRC-1:0] src_instr,
    input  logic                  cpu_busy,
    input  logic                  cpu_ack,
    output logic                  irq_valid,
    output logic [31:0]           irq_instruction,
    output logic                  frame_tick,
    output logic [NUM_SRC-1:0]    pending,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int C_IDX_W   = (clog2(NUM_SRC) < 1) ? 1 : clog2(NUM_SRC);
    localparam int C_FRAME_W = (clog2(FRAME_DIV) < 1) ? 1 : clog2(FRAME_DIV);
    localparam logic [C_FRAME_W-1:0] C_FRAME_LAST = C_FRAME_W'(FRAME_DIV - 1);
`ifndef IRQ_ONESHOT_EN
    localparam int C_TO_W = (clog2(ACK_TIMEOUT) < 1) ? 1 : clog2(ACK_TIMEOUT);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(ACK_TIMEOUT - 1);
`endif

    state_t                r_state;
    logic [C_FRAME_W-1:0]  r_frame_cnt;
    logic [NUM_SRC-2:0]    r_evt_prev;
    logic [NUM_SRC-1:0]    r_pending;
    logic [DROP_W-1:0]     r_drop_count;
    logic [C_IDX_W-1:0]    r_ptr;
    logic [C_IDX_W-1:0]    r_grant;
    logic                  r_irq_valid;
    logic [31:0]           r_irq_instr;
`ifndef IRQ_ONESHOT_EN
    logic [C_TO_W-1:0]     r_wait_cnt;
`endif

    logic                  w_frame_last;
    logic [NUM_SRC-1:0]    w_set;
    logic [NUM_SRC-1:0]    w_clr;
    logic [NUM_SRC-1:0]    w_drop;
    logic [DROP_W:0]       w_drop_sum;
    logic [C_IDX_W-1:0]    w_grant_idx;
    logic                  w_grant_valid;
    logic [31:0]           w_grant_instr;
    logic [C_IDX_W-1:0]    w_ptr_next;
    logic                  w_clear_en;
    logic                  w_leave;

    assign w_frame_last    = (r_frame_cnt == C_FRAME_LAST);
    assign w_set           = {src_evt & ~r_evt_prev, w_frame_last};
    assign w_drop          = w_set & r_pending & ~w_clr;
    assign w_ptr_next      = (int'(r_grant) == NUM_SRC - 1) ? '0 : r_grant + 1'b1;

`ifdef IRQ_ONESHOT_EN
    assign w_clear_en      = (r_state == ISSUE);
    assign w_leave         = (r_state == ISSUE);
`else
    assign w_clear_en      = (r_state == ISSUE) && cpu_ack;
    assign w_leave         = (r_state == ISSUE) && (cpu_ack || (r_wait_cnt == C_TO_LAST));
`endif

    assign frame_tick      = w_frame_last;
    assign pending         = r_pending;
    assign drop_count      = r_drop_count;
    assign irq_valid       = r_irq_valid;
    assign irq_instruction = r_irq_instr;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (C_IDX_W)
    ) u_rr_arbiter (
        .pending     (r_pending),
        .pointer     (r_ptr),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    always_comb begin
        w_grant_instr = '0;
        w_clr         = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(w_grant_idx) == i) w_grant_instr = src_instr[32*i +: 32];
            if (w_clear_en && (int'(r_grant) == i)) w_clr[i] = 1'b1;
        end
    end

    // Drops are counted per source; the carry bit of the sum flags saturation.
    always_comb begin
        w_drop_sum = {1'b0, r_drop_count};
        for (int i = 0; i < NUM_SRC; i++) begin
            w_drop_sum = w_drop_sum + {{DROP_W{1'b0}}, w_drop[i]};
        end
    end

    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt  <= '0;
            r_evt_prev   <= '0;
            r_pending    <= '0;
            r_drop_count <= '0;
        end else begin
            r_frame_cnt  <= w_frame_last ? '0 : r_frame_cnt + 1'b1;
            r_evt_prev   <= src_evt;
            // A new event on the source being cleared this cycle stays pending.
            r_pending    <= (r_pending & ~w_clr) | w_set;
            r_drop_count <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_irq_valid <= 1'b0;
            r_irq_instr <= '0;
`ifndef IRQ_ONESHOT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid && !cpu_busy) begin
                        r_state     <= ISSUE;
                        r_grant     <= w_grant_idx;
                        r_irq_valid <= 1'b1;
                        r_irq_instr <= w_grant_instr;
`ifndef IRQ_ONESHOT_EN
                        r_wait_cnt  <= '0;
`endif
                    end
                end
                ISSUE: begin
                    // Timeout also advances the pointer so a stuck source cannot starve others.
                    if (w_leave) begin
                        r_state     <= IDLE;
                        r_ptr       <= w_ptr_next;
                        r_irq_valid <= 1'b0;
                        r_irq_instr <= '0;
                    end
`ifndef IRQ_ONESHOT_EN
                    else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
